// File: rtl/scratch_pad_arbiter_if.sv
// rtl/scratch_pad_arbiter_if.sv - requester A/B and scratch-pad signal bundle for scratch_pad_arbiter
interface scratch_pad_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 4
);
  logic          a_req;
  logic          a_wr;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_ack;
  logic          a_err;
  logic [DW-1:0] a_rdata;

  logic          b_req;
  logic          b_wr;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_ack;
  logic          b_err;
  logic [DW-1:0] b_rdata;

  logic [DW-1:0] sp_di;
  logic          sp1_re;
  logic          sp1_we;
  logic          sp2_re;
  logic          sp2_we;
  logic [DW-1:0] sp_do;
  logic          busy;

  modport master (
    output a_req, a_wr, a_addr, a_wdata,
    input  a_ack, a_err, a_rdata,
    output b_req, b_wr, b_addr, b_wdata,
    input  b_ack, b_err, b_rdata,
    input  sp_di, sp1_re, sp1_we, sp2_re, sp2_we, busy,
    output sp_do
  );

  modport slave (
    input  a_req, a_wr, a_addr, a_wdata,
    output a_ack, a_err, a_rdata,
    input  b_req, b_wr, b_addr, b_wdata,
    output b_ack, b_err, b_rdata,
    output sp_di, sp1_re, sp1_we, sp2_re, sp2_we, busy,
    input  sp_do
  );
endinterface

// File: rtl/scratch_pad_arbiter.sv
// rtl/scratch_pad_arbiter.sv - round-robin A/B arbiter for the SP1/SP2 scratch-pad register pair
module scratch_pad_arbiter #(
  parameter int            DW             = 32,
  parameter int            AW             = 4,
  parameter logic [AW-1:0] SP1_ADDR       = 'h0,
  parameter logic [AW-1:0] SP2_ADDR       = 'h4,
  parameter logic [DW-1:0] UNMAPPED_RDATA = DW'(32'hDEADC0DE)
) (
  input  logic               opb_clk,
  input  logic               opb_rst_n,
  scratch_pad_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RWAIT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state;
  logic          ptr_b;
  logic          gnt_b;
  logic          wr_q;
  logic [DW-1:0] sp_di;
  logic          sp1_re, sp1_we, sp2_re, sp2_we;
  logic          a_ack, a_err, b_ack, b_err;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          busy;

  logic          pick_b;
  logic          sel_wr;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          hit1, hit2;

  // ptr_b set means B was not served last and wins a tie
  assign pick_b    = (bus.a_req && bus.b_req) ? ptr_b : bus.b_req;
  assign sel_wr    = pick_b ? bus.b_wr    : bus.a_wr;
  assign sel_addr  = pick_b ? bus.b_addr  : bus.a_addr;
  assign sel_wdata = pick_b ? bus.b_wdata : bus.a_wdata;
  assign hit1      = (sel_addr == SP1_ADDR);
  assign hit2      = !hit1 && (sel_addr == SP2_ADDR);

  always_ff @(posedge opb_clk or negedge opb_rst_n) begin
    if (!opb_rst_n) begin
      state   <= S_IDLE;
      ptr_b   <= 1'b0;
      gnt_b   <= 1'b0;
      wr_q    <= 1'b0;
      sp_di   <= '0;
      sp1_re  <= 1'b0;
      sp1_we  <= 1'b0;
      sp2_re  <= 1'b0;
      sp2_we  <= 1'b0;
      a_ack   <= 1'b0;
      a_err   <= 1'b0;
      b_ack   <= 1'b0;
      b_err   <= 1'b0;
      a_rdata <= '0;
      b_rdata <= '0;
      busy    <= 1'b0;
    end else begin
      sp1_re <= 1'b0;
      sp1_we <= 1'b0;
      sp2_re <= 1'b0;
      sp2_we <= 1'b0;
      a_ack  <= 1'b0;
      a_err  <= 1'b0;
      b_ack  <= 1'b0;
      b_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.a_req || bus.b_req) begin
            gnt_b <= pick_b;
            ptr_b <= ~pick_b;
            wr_q  <= sel_wr;
            sp_di <= sel_wdata;
            busy  <= 1'b1;
            if (hit1 || hit2) begin
              state  <= S_ISSUE;
              sp1_re <= hit1 && !sel_wr;
              sp1_we <= hit1 && sel_wr;
              sp2_re <= hit2 && !sel_wr;
              sp2_we <= hit2 && sel_wr;
            end else begin
              state <= S_DONE;
              a_ack <= !pick_b;
              a_err <= !pick_b;
              b_ack <= pick_b;
              b_err <= pick_b;
              if (!sel_wr) begin
                if (pick_b) b_rdata <= UNMAPPED_RDATA;
                else        a_rdata <= UNMAPPED_RDATA;
              end
            end
          end
        end
        S_ISSUE: begin
          if (wr_q) begin
            state <= S_DONE;
            a_ack <= !gnt_b;
            b_ack <= gnt_b;
          end else begin
            state <= S_RWAIT;
          end
        end
        S_RWAIT: begin
          // pad read data is registered, so it is only valid in this cycle
          state <= S_DONE;
          a_ack <= !gnt_b;
          b_ack <= gnt_b;
          if (gnt_b) b_rdata <= bus.sp_do;
          else       a_rdata <= bus.sp_do;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sp_di   = sp_di;
  assign bus.sp1_re  = sp1_re;
  assign bus.sp1_we  = sp1_we;
  assign bus.sp2_re  = sp2_re;
  assign bus.sp2_we  = sp2_we;
  assign bus.a_ack   = a_ack;
  assign bus.a_err   = a_err;
  assign bus.a_rdata = a_rdata;
  assign bus.b_ack   = b_ack;
  assign bus.b_err   = b_err;
  assign bus.b_rdata = b_rdata;
  assign bus.busy    = busy;

endmodule

// File: tb/tb_scratch_pad_arbiter.sv
// tb/tb_scratch_pad_arbiter.sv - scoreboard bench for scratch_pad_arbiter with a pad model and reference model
module tb_scratch_pad_arbiter;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam logic [DW-1:0] UNMAPPED = 32'hDEADC0DE;

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            lat;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  scratch_pad_arbiter_if #(.DW(DW), .AW(AW)) bus ();

  scratch_pad_arbiter #(.DW(DW), .AW(AW)) dut (
    .opb_clk   (clk),
    .opb_rst_n (rst_n),
    .bus       (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scratch-pad environment: registered read data one cycle after RE
  logic [DW-1:0] pad1, pad2;
  always @(posedge clk) begin
    if (bus.sp1_we) pad1 <= bus.sp_di;
    if (bus.sp2_we) pad2 <= bus.sp_di;
    if (bus.sp1_re)      bus.sp_do <= pad1;
    else if (bus.sp2_re) bus.sp_do <= pad2;
  end

  // reference model state, updated in completion order
  logic [DW-1:0] mem [2];
  logic [DW-1:0] exp_rdata [2];
  int            last_b = 1;
  txn_t cmd_a[$], cmd_b[$], sb_a[$], sb_b[$];
  int   order_q[$];
  int   issue_cyc [2];

  int            strobe_n = 0;
  bit            st_pad2, st_wr;
  logic [DW-1:0] st_di;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic check_ack(input int who);
    txn_t t;
    bit err_e, pad2_e;
    logic err_a;
    logic [DW-1:0] rd_me, rd_other;
    if ((who == 0 && sb_a.size() == 0) || (who == 1 && sb_b.size() == 0)) begin
      chk("unexpected_ack", 64'(who), 64'hFF);
      return;
    end
    if (who == 0) t = sb_a.pop_front();
    else          t = sb_b.pop_front();
    err_e  = !(t.addr == 4'h0 || t.addr == 4'h4);
    pad2_e = (t.addr == 4'h4);
    if (order_q.size() > 0) chk("grant_order", 64'(who), 64'(order_q.pop_front()));
    err_a    = (who == 0) ? bus.a_err : bus.b_err;
    rd_me    = (who == 0) ? bus.a_rdata : bus.b_rdata;
    rd_other = (who == 0) ? bus.b_rdata : bus.a_rdata;
    chk("err", 64'(err_a), 64'(err_e));
    if (err_e) begin
      chk("strobe_count_unmapped", 64'(strobe_n), 0);
      if (!t.wr) exp_rdata[who] = UNMAPPED;
    end else begin
      chk("strobe_count", 64'(strobe_n), 1);
      chk("strobe_pad", 64'(st_pad2), 64'(pad2_e));
      chk("strobe_dir", 64'(st_wr), 64'(t.wr));
      if (t.wr) begin
        chk("sp_di", 64'(st_di), 64'(t.wdata));
        mem[pad2_e] = t.wdata;
      end else begin
        exp_rdata[who] = mem[pad2_e];
      end
    end
    chk("rdata", 64'(rd_me), 64'(exp_rdata[who]));
    chk("rdata_other_held", 64'(rd_other), 64'(exp_rdata[1-who]));
    if (t.lat >= 0) chk("latency", 64'(cyc - issue_cyc[who]), 64'(t.lat));
    last_b   = who;
    strobe_n = 0;
  endtask

  always @(negedge clk) begin : monitor
    int ns;
    if (rst_n) begin
      ns = int'(bus.sp1_re) + int'(bus.sp1_we) + int'(bus.sp2_re) + int'(bus.sp2_we);
      if (ns != 0) begin
        chk("one_strobe", 64'(ns), 1);
        chk("busy_with_strobe", 64'(bus.busy), 1);
        strobe_n++;
        st_pad2 = bus.sp2_re | bus.sp2_we;
        st_wr   = bus.sp1_we | bus.sp2_we;
        st_di   = bus.sp_di;
      end
      if (bus.a_ack && bus.b_ack) chk("dual_ack", 2'b11, 2'b01);
      else if (bus.a_ack)         check_ack(0);
      else if (bus.b_ack)         check_ack(1);
    end
  end

  task automatic push(input int who, input bit wr, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wdata, input bit solo);
    txn_t t;
    t.wr = wr; t.addr = addr; t.wdata = wdata;
    if (!solo)                                t.lat = -1;
    else if (!(addr == 4'h0 || addr == 4'h4)) t.lat = 1;
    else if (wr)                              t.lat = 2;
    else                                      t.lat = 3;
    if (who == 0) begin cmd_a.push_back(t); sb_a.push_back(t); end
    else          begin cmd_b.push_back(t); sb_b.push_back(t); end
  endtask

  function automatic bit ack_of(input int who);
    return (who == 0) ? bus.a_ack : bus.b_ack;
  endfunction

  task automatic set_req(input int who, input bit req, input txn_t t);
    if (who == 0) begin
      bus.a_req = req; bus.a_wr = t.wr; bus.a_addr = t.addr; bus.a_wdata = t.wdata;
    end else begin
      bus.b_req = req; bus.b_wr = t.wr; bus.b_addr = t.addr; bus.b_wdata = t.wdata;
    end
  endtask

  // called just after a rising edge; returns just after the edge ending the last ACK
  task automatic drive(input int who);
    txn_t t;
    bit got;
    while ((who == 0 ? cmd_a.size() : cmd_b.size()) != 0) begin
      if (who == 0) t = cmd_a.pop_front();
      else          t = cmd_b.pop_front();
      set_req(who, 1'b1, t);
      issue_cyc[who] = cyc;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
        @(negedge clk);
        if (ack_of(who)) got = 1'b1;
      end
      if (!got) chk("ack_timeout", 64'(who), 64'hAC);
      @(posedge clk);
      #1;
    end
    t.wr = 1'b0; t.addr = '0; t.wdata = '0;
    set_req(who, 1'b0, t);
  endtask

  task automatic run_phase();
    @(posedge clk);
    #1;
    fork
      drive(0);
      drive(1);
    join
    repeat (2) @(posedge clk);
  endtask

  task automatic expect_order(input int na, input int nb);
    int cur, ra, rb;
    cur = last_b ? 0 : 1;
    ra = na; rb = nb;
    while (ra + rb > 0) begin
      if ((cur == 0 && ra == 0) || (cur == 1 && rb == 0)) cur = 1 - cur;
      order_q.push_back(cur);
      if (cur == 0) ra--; else rb--;
      cur = 1 - cur;
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return 4'h0;
      1:       return 4'h4;
      2:       return 4'h8;
      default: return AW'($urandom);
    endcase
  endfunction

  task automatic reset_model();
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    last_b       = 1;
    strobe_n     = 0;
  endtask

  initial begin : stim
    txn_t idle;
    bit   got;
    idle.wr = 1'b0; idle.addr = '0; idle.wdata = '0; idle.lat = -1;
    set_req(0, 1'b0, idle);
    set_req(1, 1'b0, idle);
    pad1 = $urandom; pad2 = $urandom;
    mem[0] = pad1; mem[1] = pad2;
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(bus.busy), 0);
    chk("rst_a_ack", 64'(bus.a_ack), 0);
    chk("rst_b_ack", 64'(bus.b_ack), 0);
    chk("rst_a_err", 64'(bus.a_err), 0);
    chk("rst_strobes", 64'({bus.sp1_re, bus.sp1_we, bus.sp2_re, bus.sp2_we}), 0);
    chk("rst_sp_di", 64'(bus.sp_di), 0);
    chk("rst_a_rdata", 64'(bus.a_rdata), 0);
    chk("rst_b_rdata", 64'(bus.b_rdata), 0);
    @(negedge clk);
    rst_n = 1'b1;

    push(0, 1'b1, 4'h0, 32'hCAFEF00D, 1'b1);
    run_phase();
    push(0, 1'b1, 4'h4, 32'h9ABCBEEF, 1'b1);
    push(0, 1'b0, 4'h4, '0, 1'b1);
    run_phase();
    push(1, 1'b0, 4'h8, '0, 1'b1);
    run_phase();

    for (int i = 0; i < 4; i++) begin
      push(0, i[0], rand_addr(), $urandom, 1'b0);
      push(1, !i[0], rand_addr(), $urandom, 1'b0);
    end
    expect_order(4, 4);
    run_phase();

    push(0, 1'b1, 4'h4, 32'h0000_1111, 1'b1);
    run_phase();
    push(1, 1'b0, 4'h4, '0, 1'b1);
    run_phase();

    for (int r = 0; r < 14; r++) begin
      int na, nb;
      na = $urandom_range(0, 3);
      nb = (na == 0) ? $urandom_range(1, 3) : $urandom_range(0, 3);
      for (int k = 0; k < na; k++) push(0, 1'($urandom), rand_addr(), $urandom, nb == 0);
      for (int k = 0; k < nb; k++) push(1, 1'($urandom), rand_addr(), $urandom, na == 0);
      if (na > 0 && nb > 0) expect_order(na, nb);
      run_phase();
    end

    // reset during the write strobe must abort the access
    @(posedge clk);
    #1;
    idle.wr = 1'b1; idle.addr = 4'h0; idle.wdata = 32'h5555AAAA;
    set_req(0, 1'b1, idle);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (bus.sp1_we) got = 1'b1;
    end
    chk("reset_test_strobe_seen", 64'(got), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_strobe_drop", 64'(bus.sp1_we), 0);
    chk("async_busy_drop", 64'(bus.busy), 0);
    idle.wr = 1'b0; idle.addr = '0; idle.wdata = '0;
    set_req(0, 1'b0, idle);
    reset_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_busy", 64'(bus.busy), 0);
    chk("post_reset_a_rdata", 64'(bus.a_rdata), 0);
    chk("pad1_unchanged", 64'(pad1), 64'(mem[0]));
    push(0, 1'b0, 4'h0, '0, 1'b1);
    run_phase();
    push(1, 1'b0, 4'h0, '0, 1'b0);
    push(0, 1'b0, 4'h4, '0, 1'b0);
    expect_order(1, 1);
    run_phase();

    repeat (4) @(posedge clk);
    chk("scoreboard_drained", 64'(sb_a.size() + sb_b.size() + order_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
